// File: rtl/level_gen_pkg.sv
// Shared types and default parameter values for the level_gen event-to-level converter.
package level_gen_pkg;

    localparam int CNT_W_DEFAULT      = 4;
    localparam int GAP_CYCLES_DEFAULT = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } state_t;

endpackage

// File: rtl/level_gen.sv
// level_gen: converts single-cycle event strobes into one acknowledged request level per event.
// Define LEVEL_GEN_OVERFLOW_EN to build the sticky overflow flag; otherwise overflow_o is tied low.
module level_gen
    import level_gen_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEFAULT,
    parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             pulse_in_i,
    input  logic             ack_i,
    output logic             level_out_o,
    output logic [CNT_W-1:0] pending_o,
    output logic             overflow_o
);

    localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             ack_acc;

    // Saturating count update; a simultaneous event and accepted ack cancel out.
    function automatic logic [CNT_W-1:0] pend_update(input logic [CNT_W-1:0] cnt,
                                                     input logic inc,
                                                     input logic dec);
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (inc && !dec && (cnt != PEND_MAX)) begin
            nxt = cnt + CNT_W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            nxt = cnt - CNT_W'(1);
        end
        return nxt;
    endfunction

    always_comb begin
        ack_acc = (state_q == ASSERT) && ack_i;
        pend_d  = pend_update(pend_q, pulse_in_i, ack_acc);
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        unique case (state_q)
            IDLE: begin
                if (pulse_in_i) begin
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (ack_i) begin
                    state_d = GAP;
                    gap_d   = '0;
                end
            end
            GAP: begin
                // Exit decision uses the count including this cycle's event.
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = (pend_d != '0) ? ASSERT : IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gap_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            pend_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            gap_q   <= gap_d;
        end
    end

    assign level_out_o = (state_q == ASSERT);
    assign pending_o   = pend_q;

`ifdef LEVEL_GEN_OVERFLOW_EN
    logic ovf_q, ovf_d;

    // An event is dropped only when it is not cancelled by an accepted ack.
    assign ovf_d = ovf_q | (pulse_in_i && !ack_acc && (pend_q == PEND_MAX));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow_o = ovf_q;
`else
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_level_gen.sv
// Self-checking bench for level_gen (CNT_W=2, GAP_CYCLES=2) using a queue of expected outputs.
module tb_level_gen;

    localparam int TB_CNT_W = 2;
`ifdef LEVEL_GEN_OVERFLOW_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    typedef struct {
        logic                lvl;
        logic [TB_CNT_W-1:0] pend;
        logic                ovf;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                pulse;
    logic                ack;
    logic                lvl;
    logic [TB_CNT_W-1:0] pend;
    logic                ovf;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    level_gen #(.CNT_W(TB_CNT_W), .GAP_CYCLES(2)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .pulse_in_i (pulse),
        .ack_i      (ack),
        .level_out_o(lvl),
        .pending_o  (pend),
        .overflow_o (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        pulse = 1'b0;
        ack   = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        pulse = 1'b1;
        ack   = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (lvl !== 1'b0) begin n_bad++; $display("FAIL reset level got %b want 0", lvl); end
        n_cmp++; if (pend !== '0) begin n_bad++; $display("FAIL reset pending got %0d want 0", pend); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset overflow got %b want 0", ovf); end
        rst_n = 1'b1;
        exp_q.push_back('{lvl: 1'b1, pend: TB_CNT_W'(1), ovf: 1'b0});
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_cmp++; if (lvl !== e.lvl) begin n_bad++; $display("FAIL first_event level got %b want %b", lvl, e.lvl); end
        n_cmp++; if (pend !== e.pend) begin n_bad++; $display("FAIL first_event pending got %0d want %0d", pend, e.pend); end
        pulse = 1'b0;
    endtask

    task automatic test_single();
        // columns: pulse, ack, expected level, expected pending (after the edge)
        int tbl[8][4] = '{'{0,0,0,0}, '{1,0,1,1}, '{0,0,1,1}, '{0,0,1,1},
                          '{0,1,0,0}, '{0,0,0,0}, '{0,0,0,0}, '{0,1,0,0}};
        exp_t e;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pulse = tbl[i][0][0];
            ack   = tbl[i][1][0];
            exp_q.push_back('{lvl: tbl[i][2][0], pend: TB_CNT_W'(tbl[i][3]), ovf: 1'b0});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++; if (lvl !== e.lvl) begin n_bad++; $display("FAIL single r%0d level got %b want %b", i, lvl, e.lvl); end
            n_cmp++; if (pend !== e.pend) begin n_bad++; $display("FAIL single r%0d pending got %0d want %0d", i, pend, e.pend); end
        end
        pulse = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic test_back_to_back();
        int tbl[11][4] = '{'{1,1,1,1}, '{1,1,0,1}, '{1,1,0,2}, '{0,1,1,2},
                           '{0,1,0,1}, '{0,1,0,1}, '{0,1,1,1}, '{0,1,0,0},
                           '{0,1,0,0}, '{0,1,0,0}, '{0,0,0,0}};
        exp_t e;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            pulse = tbl[i][0][0];
            ack   = tbl[i][1][0];
            exp_q.push_back('{lvl: tbl[i][2][0], pend: TB_CNT_W'(tbl[i][3]), ovf: 1'b0});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++; if (lvl !== e.lvl) begin n_bad++; $display("FAIL burst r%0d level got %b want %b", i, lvl, e.lvl); end
            n_cmp++; if (pend !== e.pend) begin n_bad++; $display("FAIL burst r%0d pending got %0d want %0d", i, pend, e.pend); end
        end
        pulse = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic test_simultaneous();
        int tbl[11][4] = '{'{1,0,1,1}, '{1,0,1,2}, '{1,1,0,2}, '{0,0,0,2},
                           '{0,0,1,2}, '{0,1,0,1}, '{0,1,0,1}, '{0,0,1,1},
                           '{0,1,0,0}, '{0,0,0,0}, '{0,0,0,0}};
        exp_t e;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            pulse = tbl[i][0][0];
            ack   = tbl[i][1][0];
            exp_q.push_back('{lvl: tbl[i][2][0], pend: TB_CNT_W'(tbl[i][3]), ovf: 1'b0});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++; if (lvl !== e.lvl) begin n_bad++; $display("FAIL simul r%0d level got %b want %b", i, lvl, e.lvl); end
            n_cmp++; if (pend !== e.pend) begin n_bad++; $display("FAIL simul r%0d pending got %0d want %0d", i, pend, e.pend); end
            n_cmp++; if (ovf !== e.ovf) begin n_bad++; $display("FAIL simul r%0d overflow got %b want %b", i, ovf, e.ovf); end
        end
        pulse = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic test_saturation();
        // columns: pulse, ack, level, pending, overflow-if-built; ends in ASSERT with pending 2
        int tbl[11][5] = '{'{1,0,1,1,0}, '{1,0,1,2,0}, '{1,0,1,3,0}, '{1,0,1,3,1},
                           '{1,0,1,3,1}, '{1,1,0,3,1}, '{0,0,0,3,1}, '{0,0,1,3,1},
                           '{0,1,0,2,1}, '{0,0,0,2,1}, '{0,0,1,2,1}};
        exp_t e;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            pulse = tbl[i][0][0];
            ack   = tbl[i][1][0];
            exp_q.push_back('{lvl: tbl[i][2][0], pend: TB_CNT_W'(tbl[i][3]), ovf: tbl[i][4][0] & OVF_ON});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++; if (lvl !== e.lvl) begin n_bad++; $display("FAIL sat r%0d level got %b want %b", i, lvl, e.lvl); end
            n_cmp++; if (pend !== e.pend) begin n_bad++; $display("FAIL sat r%0d pending got %0d want %0d", i, pend, e.pend); end
            n_cmp++; if (ovf !== e.ovf) begin n_bad++; $display("FAIL sat r%0d overflow got %b want %b", i, ovf, e.ovf); end
        end
        pulse = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        n_cmp++; if (lvl !== 1'b1 || pend !== TB_CNT_W'(2)) begin
            n_bad++; $display("FAIL mid_setup level/pending got %b/%0d want 1/2", lvl, pend);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (lvl !== 1'b0) begin n_bad++; $display("FAIL mid_reset level got %b want 0", lvl); end
        n_cmp++; if (pend !== '0) begin n_bad++; $display("FAIL mid_reset pending got %0d want 0", pend); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL mid_reset overflow got %b want 0", ovf); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulse = 1'b1;
        exp_q.push_back('{lvl: 1'b1, pend: TB_CNT_W'(1), ovf: 1'b0});
        @(posedge clk); #1;
        pulse = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if (lvl !== e.lvl) begin n_bad++; $display("FAIL post_reset level got %b want %b", lvl, e.lvl); end
        n_cmp++; if (pend !== e.pend) begin n_bad++; $display("FAIL post_reset pending got %0d want %0d", pend, e.pend); end
        n_cmp++; if (ovf !== e.ovf) begin n_bad++; $display("FAIL post_reset overflow got %b want %b", ovf, e.ovf); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_simultaneous();
        test_saturation();
        test_reset_mid();
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard leftover got %0d want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
